delay_load_ctrl: RTL and testbench
==================================

Name: delay_load_ctrl

Overview:
- Sequences software delay updates into the F-engine coarse-delay bank.
- Watches the 32-bit delay_data software register output (user_clk domain) and decodes a toggle-triggered load request.
- Holds the request until the next sync pulse, or applies it immediately, then writes antenna index and delay into the delay bank with a valid/ready handshake.
- Exposes a status word for a ppc-readable register.

Parameters:
- N_ANT, 16, number of antennas / delay-bank entries (1..64).
- ANT_W, 6, width of antenna index field and dly_addr.
- DELAY_W, 16, delay value width (≤16).
- TIMEOUT_CYC, 1024, handshake timeout in cycles (only used with DELAY_LOAD_TIMEOUT_EN).

Ports:
- user_clk  in  1  sole clock.
- user_rst  in  1  synchronous, active-high reset.
- cfg_word  in  32  delay_data register value: [31] load toggle, [30] immediate (ignore sync), [29:24] antenna index, [DELAY_W-1:0] delay.
- sync_in  in  1  one-cycle system sync pulse.
- status_clr  in  1  level from software register; rising edge clears sticky flags.
- dly_valid  out  1  write request to delay bank.
- dly_ready  in  1  delay bank accepts when dly_valid && dly_ready.
- dly_addr  out  ANT_W  antenna index.
- dly_data  out  DELAY_W  delay value.
- status_word  out  32  [31] busy, [30] overrun, [29] range_err, [28] timeout, [27:16] zero, [15:0] applied-load count.

Behaviour:
- Clocking and reset:
  - One clock domain, user_clk.
  - user_rst is synchronous, active-high.
  - Reset values: dly_valid=0, dly_addr=0, dly_data=0, status_word=0, state=IDLE, prev_toggle=0, primed=0.
- Priming:
  - The first cycle after reset loads prev_toggle←cfg_word[31] and sets primed; no load is decoded on that cycle.
  - A toggle left high across reset therefore never fires.
- Request detect: req = primed && (cfg_word[31] != prev_toggle). prev_toggle updates every cycle.
- Capture on req:
  - Latch ant=cfg[29:24], dly=cfg[DELAY_W-1:0], imm=cfg[30].
  - If ant ≥ N_ANT: set range_err (sticky), discard the request, leave state unchanged.
- States:
  - IDLE: valid req → imm ? ISSUE : ARMED.
  - ARMED: wait for sync_in.
    - sync_in → ISSUE next cycle.
    - A new valid req in ARMED replaces the latched request (latest wins) and sets overrun.
    - req and sync_in in the same cycle: the new request is latched and is the one issued; overrun is set.
  - ISSUE:
    - dly_valid=1, dly_addr/dly_data are stable and held until the handshake completes.
    - On dly_valid&&dly_ready: deassert dly_valid next cycle and → DONE.
    - A req during ISSUE sets overrun and is dropped; the held write is never changed.
  - DONE: one cycle; count←count+1 (wraps 0xFFFF→0); → IDLE.
- busy = (state != IDLE).
- Latency:
  - imm request: req cycle N, dly_valid high at N+1.
  - Synced request: sync_in at cycle M, dly_valid high at M+1.
  - A sync_in arriving in the same cycle as req (non-imm, from IDLE) is not used; the request waits for the next sync.
- status_clr:
  - Rising edge clears overrun, range_err and timeout in the following cycle.
  - A flag event in the same cycle as the clear wins (flag stays set).
  - Count is not cleared.
- Reset mid-operation aborts any pending or issuing write; dly_valid drops the cycle after user_rst is sampled.

Optional Feature:
- Macro: DELAY_LOAD_TIMEOUT_EN.
- With it defined:
  - ISSUE runs a counter cleared on ISSUE entry.
  - If TIMEOUT_CYC cycles elapse without handshake: drop dly_valid, set timeout (sticky), → IDLE; count is not incremented.
- Without it:
  - ISSUE waits indefinitely.
  - status_word[28] is tied 0 and no counter logic exists.

Test Plan:
- Reset with cfg_word=0x8000_0000, then hold it → no dly_valid ever, status_word=0.
- cfg_word toggles to 0xC300_0123 (imm, ant 3, delay 0x0123), dly_ready=1 → dly_valid one cycle later with addr=3, data=0x0123; status count=1, busy low two cycles later.
- Non-imm request ant 5 delay 0x0040, sync_in 20 cycles later, dly_ready held low 5 cycles → dly_valid at sync+1 and held stable 6 cycles; count increments after the handshake.
- In ARMED, issue a second toggle (ant 7, delay 0x0099) then sync_in → single write addr=7 data=0x0099; overrun=1; status_clr rising edge → overrun=0.
- Request with ant=20 (N_ANT=16) → no write, range_err=1, busy stays 0.
- With DELAY_LOAD_TIMEOUT_EN and TIMEOUT_CYC=8, dly_ready=0 → dly_valid drops after 8 cycles, timeout=1, count unchanged; without the macro dly_valid stays high.

Source files
------------

// File: rtl/delay_load_ctrl.sv
// delay_load_ctrl: sequences software delay updates from the delay_data register
// into the coarse-delay bank over a valid/ready write port.
// Optional build macro: DELAY_LOAD_TIMEOUT_EN adds a handshake timeout in ISSUE.
module delay_load_ctrl #(
    parameter int unsigned N_ANT       = 16,
    parameter int unsigned ANT_W       = 6,
    parameter int unsigned DELAY_W     = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               user_clk,
    input  logic               user_rst,
    input  logic [31:0]        cfg_word,
    input  logic               sync_in,
    input  logic               status_clr,
    output logic               dly_valid,
    input  logic               dly_ready,
    output logic [ANT_W-1:0]   dly_addr,
    output logic [DELAY_W-1:0] dly_data,
    output logic [31:0]        status_word
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int unsigned CNT_W = 16;

    logic [1:0]         r_state;
    logic               r_prev_toggle;
    logic               r_primed;
    logic               r_clr_prev;
    logic [ANT_W-1:0]   r_ant;
    logic [DELAY_W-1:0] r_dly;
    logic               r_busy;
    logic               r_overrun;
    logic               r_range_err;
    logic [CNT_W-1:0]   r_count;

    logic [1:0]         w_state_nxt;
    logic [ANT_W-1:0]   w_ant_nxt;
    logic [DELAY_W-1:0] w_dly_nxt;
    logic               w_valid_nxt;
    logic [ANT_W-1:0]   w_addr_nxt;
    logic [DELAY_W-1:0] w_data_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_overrun_evt;
    logic               w_issue_go;
    logic               w_timeout;

    logic [5:0]         w_cfg_ant_raw;
    logic [ANT_W-1:0]   w_cfg_ant;
    logic [DELAY_W-1:0] w_cfg_dly;
    logic               w_cfg_imm;
    logic               w_req;
    logic               w_range_bad;
    logic               w_req_ok;
    logic               w_range_evt;
    logic               w_clr_rise;
    logic               w_unused_cfg;

    // Field decode of the software register and toggle-based request detect
    assign w_cfg_ant_raw = cfg_word[29:24];
    assign w_cfg_ant     = ANT_W'(w_cfg_ant_raw);
    assign w_cfg_dly     = cfg_word[DELAY_W-1:0];
    assign w_cfg_imm     = cfg_word[30];
    assign w_req         = r_primed && (cfg_word[31] != r_prev_toggle);
    assign w_range_bad   = 32'(w_cfg_ant_raw) >= N_ANT;
    assign w_req_ok      = w_req && !w_range_bad;
    assign w_range_evt   = w_req && w_range_bad;
    assign w_clr_rise    = status_clr && !r_clr_prev;
    assign w_unused_cfg  = ^cfg_word;

`ifdef DELAY_LOAD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] w_tmo_cnt_nxt;
    logic             w_tmo_evt;
    logic             r_timeout;

    assign w_timeout = r_timeout;
`else
    logic [31:0] w_unused_tmo;

    assign w_unused_tmo = TIMEOUT_CYC;
    assign w_timeout    = 1'b0;
`endif

    // Next-state and next-output computation for the load sequencer
    always_comb begin
        w_state_nxt   = r_state;
        w_ant_nxt     = r_ant;
        w_dly_nxt     = r_dly;
        w_valid_nxt   = dly_valid;
        w_addr_nxt    = dly_addr;
        w_data_nxt    = dly_data;
        w_count_nxt   = r_count;
        w_overrun_evt = 1'b0;
        w_issue_go    = 1'b0;
`ifdef DELAY_LOAD_TIMEOUT_EN
        w_tmo_evt     = 1'b0;
        w_tmo_cnt_nxt = r_tmo_cnt;
`endif
        case (r_state)
            S_IDLE, S_ARMED: begin
                // latest valid request wins; replacing an armed one is an overrun
                if (w_req_ok) begin
                    w_ant_nxt     = w_cfg_ant;
                    w_dly_nxt     = w_cfg_dly;
                    w_overrun_evt = (r_state == S_ARMED);
                end
                w_issue_go = (w_req_ok && w_cfg_imm) || ((r_state == S_ARMED) && sync_in);
                if (w_issue_go) begin
                    w_state_nxt = S_ISSUE;
                    w_valid_nxt = 1'b1;
                    w_addr_nxt  = w_ant_nxt;
                    w_data_nxt  = w_dly_nxt;
`ifdef DELAY_LOAD_TIMEOUT_EN
                    w_tmo_cnt_nxt = '0;
`endif
                end else if (w_req_ok) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ISSUE: begin
                // the held write is never altered; new requests are dropped
                w_overrun_evt = w_req_ok;
                if (dly_valid && dly_ready) begin
                    w_state_nxt = S_DONE;
                    w_valid_nxt = 1'b0;
                end
`ifdef DELAY_LOAD_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_tmo_evt   = 1'b1;
                end else begin
                    w_tmo_cnt_nxt = TMO_W'(r_tmo_cnt + 1'b1);
                end
`endif
            end
            S_DONE: begin
                w_overrun_evt = w_req_ok;
                w_count_nxt   = CNT_W'(r_count + 1'b1);
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, outputs and sticky status registers
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state       <= S_IDLE;
            r_prev_toggle <= 1'b0;
            r_primed      <= 1'b0;
            r_clr_prev    <= 1'b0;
            r_ant         <= '0;
            r_dly         <= '0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_range_err   <= 1'b0;
            r_count       <= '0;
            dly_valid     <= 1'b0;
            dly_addr      <= '0;
            dly_data      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_toggle <= cfg_word[31];
            r_primed      <= 1'b1;
            r_clr_prev    <= status_clr;
            r_ant         <= w_ant_nxt;
            r_dly         <= w_dly_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_overrun     <= w_overrun_evt | (r_overrun & ~w_clr_rise);
            r_range_err   <= w_range_evt | (r_range_err & ~w_clr_rise);
            r_count       <= w_count_nxt;
            dly_valid     <= w_valid_nxt;
            dly_addr      <= w_addr_nxt;
            dly_data      <= w_data_nxt;
        end
    end

`ifdef DELAY_LOAD_TIMEOUT_EN
    // Handshake timeout counter and its sticky flag
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_timeout <= w_tmo_evt | (r_timeout & ~w_clr_rise);
        end
    end
`endif

    assign status_word = {r_busy, r_overrun, r_range_err, w_timeout, 12'd0, r_count};

endmodule

// File: tb/tb_delay_load_ctrl.sv
// Testbench for delay_load_ctrl: directed scenarios plus random traffic,
// checked each cycle against a request/write-level reference model.
module tb_delay_load_ctrl;

    localparam int unsigned N_ANT       = 16;
    localparam int unsigned ANT_W       = 6;
    localparam int unsigned DELAY_W     = 16;
    localparam int unsigned TIMEOUT_CYC = 8;
`ifdef DELAY_LOAD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic               user_clk = 1'b0;
    logic               user_rst;
    logic [31:0]        cfg_word;
    logic               sync_in;
    logic               status_clr;
    logic               dly_valid;
    logic               dly_ready;
    logic [ANT_W-1:0]   dly_addr;
    logic [DELAY_W-1:0] dly_data;
    logic [31:0]        status_word;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    delay_load_ctrl #(
        .N_ANT(N_ANT), .ANT_W(ANT_W), .DELAY_W(DELAY_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .user_clk(user_clk), .user_rst(user_rst), .cfg_word(cfg_word),
        .sync_in(sync_in), .status_clr(status_clr), .dly_valid(dly_valid),
        .dly_ready(dly_ready), .dly_addr(dly_addr), .dly_data(dly_data),
        .status_word(status_word)
    );

    always #5 user_clk = ~user_clk;

    // Reference model: a pending (armed) request, a write in flight, a finishing slot
    bit          m_prev, m_primed, m_clr_prev;
    bit          m_armed, m_writing, m_finishing;
    bit          m_over, m_range, m_tmo;
    logic [5:0]  m_pend_ant;
    logic [15:0] m_pend_dly;
    logic [5:0]  m_addr;
    logic [15:0] m_data;
    logic [15:0] m_count;
    int unsigned m_age;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [31:0] cfg, input logic sync, input logic clr,
                              input logic ready, input logic rst);
        bit a, w, f, req, ok, go, clr_rise, ev_over, ev_range, ev_tmo;
        logic [5:0] ant;
        if (rst) begin
            m_prev = 0; m_primed = 0; m_clr_prev = 0;
            m_armed = 0; m_writing = 0; m_finishing = 0;
            m_over = 0; m_range = 0; m_tmo = 0;
            m_addr = '0; m_data = '0; m_count = '0; m_age = 0;
            return;
        end
        ant = cfg[29:24];
        a = m_armed; w = m_writing; f = m_finishing;
        req = m_primed && (cfg[31] != m_prev);
        m_prev = cfg[31]; m_primed = 1;
        clr_rise = clr && !m_clr_prev; m_clr_prev = clr;
        ev_over = 0; ev_range = 0; ev_tmo = 0;
        ok = req && (32'(ant) < N_ANT);
        if (req && !ok) ev_range = 1;
        if (f) begin
            m_count = m_count + 16'd1;
            m_finishing = 0;
            if (ok) ev_over = 1;
        end else if (w) begin
            if (ok) ev_over = 1;
            if (ready) begin
                m_writing = 0; m_finishing = 1;
            end else begin
                m_age++;
                if (TMO_EN && m_age >= TIMEOUT_CYC) begin
                    m_writing = 0; ev_tmo = 1;
                end
            end
        end else begin
            go = a && sync;
            if (ok) begin
                if (a) ev_over = 1;
                m_pend_ant = ant; m_pend_dly = cfg[15:0]; m_armed = 1;
                go = go || cfg[30];
            end
            if (go) begin
                m_armed = 0; m_writing = 1; m_age = 0;
                m_addr = m_pend_ant; m_data = m_pend_dly;
            end
        end
        m_over  = ev_over  | (m_over  & !clr_rise);
        m_range = ev_range | (m_range & !clr_rise);
        m_tmo   = ev_tmo   | (m_tmo   & !clr_rise);
    endtask

    function automatic logic [31:0] exp_status();
        return {(m_armed || m_writing || m_finishing), m_over, m_range, m_tmo, 12'd0, m_count};
    endfunction

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later
    task automatic cycle(input logic [31:0] cfg, input logic sync, input logic clr,
                         input logic ready, input logic rst);
        cfg_word = cfg; sync_in = sync; status_clr = clr; dly_ready = ready; user_rst = rst;
        @(posedge user_clk);
        model_step(cfg, sync, clr, ready, rst);
        #1;
        check_eq("valid",  32'(dly_valid), 32'(m_writing));
        check_eq("addr",   32'(dly_addr),  32'(m_addr));
        check_eq("data",   32'(dly_data),  32'(m_data));
        check_eq("status", status_word,    exp_status());
    endtask

    task automatic hold(input int unsigned n, input logic [31:0] cfg, input logic ready);
        for (int i = 0; i < int'(n); i++) cycle(cfg, 1'b0, 1'b0, ready, 1'b0);
    endtask

    initial begin
        logic [31:0] cur;
        logic        clr_lvl;
        // Toggle left high across reset never fires
        for (int i = 0; i < 3; i++) cycle(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(10, 32'h8000_0000, 1'b1);
        check_eq("idle_status", status_word, 32'h0);
        check_eq("idle_valid", 32'(dly_valid), 32'd0);

        // Immediate request
        for (int i = 0; i < 2; i++) cycle(32'h4300_0123, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(1, 32'h4300_0123, 1'b1);
        cycle(32'hC300_0123, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("imm_valid", 32'(dly_valid), 32'd1);
        check_eq("imm_addr", 32'(dly_addr), 32'd3);
        check_eq("imm_data", 32'(dly_data), 32'h0123);
        hold(2, 32'hC300_0123, 1'b1);
        check_eq("imm_done_status", status_word, 32'h0000_0001);

        // Synced request with back-pressure
        cycle(32'h0500_0040, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(19, 32'h0500_0040, 1'b0);
        check_eq("armed_busy", 32'(status_word[31]), 32'd1);
        check_eq("armed_novalid", 32'(dly_valid), 32'd0);
        cycle(32'h0500_0040, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("sync_valid", 32'(dly_valid), 32'd1);
        check_eq("sync_addr", 32'(dly_addr), 32'd5);
        hold(5, 32'h0500_0040, 1'b0);
        check_eq("sync_held_data", 32'(dly_data), 32'h0040);
        hold(3, 32'h0500_0040, 1'b1);
        check_eq("sync_count", status_word, 32'h0000_0002);

        // Replacement while armed, then clear of the overrun flag
        cycle(32'h8500_0011, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(2, 32'h8500_0011, 1'b1);
        cycle(32'h0700_0099, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("armed_overrun", 32'(status_word[30]), 32'd1);
        hold(1, 32'h0700_0099, 1'b1);
        cycle(32'h0700_0099, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("repl_addr", 32'(dly_addr), 32'd7);
        check_eq("repl_data", 32'(dly_data), 32'h0099);
        hold(3, 32'h0700_0099, 1'b1);
        cycle(32'h0700_0099, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("clr_overrun", 32'(status_word[30]), 32'd0);
        cycle(32'h0700_0099, 1'b0, 1'b0, 1'b1, 1'b0);

        // Out-of-range antenna
        cycle(32'h9400_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(2, 32'h9400_0001, 1'b1);
        check_eq("range_err", 32'(status_word[29]), 32'd1);
        check_eq("range_busy", 32'(status_word[31]), 32'd0);

        // Stalled handshake: timeout when enabled, otherwise held forever
        cycle(32'h4100_0ABC, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(12, 32'h4100_0ABC, 1'b0);
        check_eq("stall_valid", 32'(dly_valid), TMO_EN ? 32'd0 : 32'd1);
        check_eq("stall_tmo", 32'(status_word[28]), TMO_EN ? 32'd1 : 32'd0);
        check_eq("stall_count", 32'(status_word[15:0]), 32'd3);

        // Reset mid-write aborts it
        cycle(32'h4100_0ABC, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_valid", 32'(dly_valid), 32'd0);
        check_eq("rst_status", status_word, 32'h0);

        // Random traffic
        cur = 32'h4100_0ABC;
        clr_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] c;
            c = cur;
            if ($urandom_range(0, 7) == 0) c[31] = ~c[31];
            c[30]    = 1'($urandom_range(0, 1));
            c[29:24] = 6'($urandom_range(0, 23));
            c[23:0]  = 24'($urandom);
            cur = c;
            if ($urandom_range(0, 19) == 0) clr_lvl = ~clr_lvl;
            cycle(c, ($urandom_range(0, 11) == 0), clr_lvl,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 499) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
